// File: rtl/activation_lut_fetcher_if.sv
`timescale 1ns/1ps
// activation_lut_fetcher_if
//   Bundles the three streams of the activation LUT fetcher:
//     - z input stream:   in_valid / in_ready / z_in
//     - table write port: tbl_we / tbl_ready / tbl_addr / tbl_wdata
//     - operand output:   out_valid / out_ready / z_value / integer_part / base / next_data
//   master = the environment (producer of z, table loader, interpolator)
//   slave  = activation_lut_fetcher
//
// Handshake rule for every stream: a transfer happens on the rising edge
// where valid (or tbl_we) and ready are both high. Once asserted, out_valid
// stays high and its payload stays stable until that transfer happens.
interface activation_lut_fetcher_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] z_in;

    logic              tbl_we;
    logic [ADDR_W-1:0] tbl_addr;
    logic [DATA_W-1:0] tbl_wdata;
    logic              tbl_ready;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] z_value;
    logic [DATA_W-1:0] integer_part;
    logic [DATA_W-1:0] base;
    logic [DATA_W-1:0] next_data;

    modport master (
        output in_valid, z_in, tbl_we, tbl_addr, tbl_wdata, out_ready,
        input  in_ready, tbl_ready, out_valid, z_value, integer_part, base, next_data
    );

    modport slave (
        input  in_valid, z_in, tbl_we, tbl_addr, tbl_wdata, out_ready,
        output in_ready, tbl_ready, out_valid, z_value, integer_part, base, next_data
    );
endinterface

// File: rtl/activation_lut_fetcher.sv
`timescale 1ns/1ps
// activation_lut_fetcher
//   Splits a pre-activation value z into its segment (upper bits) and
//   fractional offset, reads the two bracketing samples tbl[seg] and
//   tbl[seg+1] through a single read port, and presents z, the masked
//   integer part and both samples to the interpolator.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst        synchronous active-low reset (clears FSM, outputs and table)
//   bus        activation_lut_fetcher_if.slave (z in, table write, operands out)
//   dbg_state  current FSM state (0 IDLE, 1 RD_BASE, 2 RD_NEXT, 3 OUT)
//
// Handshake: a transfer occurs on the rising edge where valid and ready are
// both high. in_ready = IDLE && !tbl_we (table writes win), tbl_ready = IDLE,
// out_valid = OUT; operands are held stable until out_ready.
module activation_lut_fetcher #(
    parameter int DATA_W    = 8,
    parameter int FRAC_BITS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    activation_lut_fetcher_if.slave      bus,
    output logic [1:0]                   dbg_state
);
    localparam int IDX_W     = DATA_W - FRAC_BITS;
    localparam int N_ENTRIES = (1 << IDX_W) + 1;
    localparam int ADDR_W    = $clog2(N_ENTRIES);
    localparam logic [DATA_W-1:0] FRAC_MASK = DATA_W'((1 << FRAC_BITS) - 1);

    typedef enum logic [1:0] {IDLE, RD_BASE, RD_NEXT, OUT} state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] tbl [N_ENTRIES];
    logic [IDX_W-1:0]  idx;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] z_q, int_q, base_q, next_q;

    logic in_ready_c, tbl_ready_c, out_valid_c;
    logic accept, tbl_wr_en;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RD_BASE;
            RD_BASE: state_nxt = RD_NEXT;
            RD_NEXT: state_nxt = OUT;
            OUT:     if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / handshake logic
    always_comb begin
        in_ready_c  = 1'b0;
        tbl_ready_c = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            IDLE: begin
                tbl_ready_c = 1'b1;
                in_ready_c  = !bus.tbl_we;
            end
            OUT:     out_valid_c = 1'b1;
            default: ;
        endcase
    end

    assign accept    = in_ready_c && bus.in_valid;
    // Writes outside IDLE or beyond the last entry are dropped silently.
    assign tbl_wr_en = (state == IDLE) && bus.tbl_we &&
                       (bus.tbl_addr < ADDR_W'(N_ENTRIES));

    // One read port: segment entry in RD_BASE, the following entry in RD_NEXT.
    // The address is one bit wider than idx so the last segment reaches the
    // extra top entry instead of wrapping to 0.
    assign rd_addr = ADDR_W'(idx) + ADDR_W'(state == RD_NEXT);
    assign rd_data = tbl[rd_addr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_ENTRIES; i++) tbl[i] <= '0;
        end else if (tbl_wr_en) begin
            tbl[bus.tbl_addr] <= bus.tbl_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            z_q    <= '0;
            int_q  <= '0;
            base_q <= '0;
            next_q <= '0;
            idx    <= '0;
        end else begin
            if (accept) begin
                z_q   <= bus.z_in;
                int_q <= bus.z_in & ~FRAC_MASK;
                idx   <= bus.z_in[DATA_W-1:FRAC_BITS];
            end
            if (state == RD_BASE) base_q <= rd_data;
            if (state == RD_NEXT) next_q <= rd_data;
        end
    end

    assign bus.in_ready     = in_ready_c;
    assign bus.tbl_ready    = tbl_ready_c;
    assign bus.out_valid    = out_valid_c;
    assign bus.z_value      = z_q;
    assign bus.integer_part = int_q;
    assign bus.base         = base_q;
    assign bus.next_data    = next_q;
    assign dbg_state        = state;
endmodule

// File: tb/tb_activation_lut_fetcher.sv
`timescale 1ns/1ps
// Testbench for activation_lut_fetcher: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// behavioural model (table array + pending-result queue + accept age).
module tb_activation_lut_fetcher;
    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 5;
    localparam int N_ENTRIES = 17;
    localparam int W         = 4 * DATA_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    activation_lut_fetcher_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
    logic [1:0] dbg_state;

    activation_lut_fetcher #(.DATA_W(DATA_W), .FRAC_BITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DATA_W-1:0] m_tbl [N_ENTRIES];
    logic [W-1:0]      exp_q [$];   // {z, integer_part, base, next} per accepted z
    int                acc_t [$];   // cycle number of each accept
    bit                started  = 0;
    bit                m_busy   = 0;
    int                m_age    = 0; // edges since accept while busy
    bit                zero_chk = 0; // outputs must read 0 (after reset, before any accept)
    int                m_cyc    = 0;
    int                n_done   = 0;

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_ENTRIES; i++) m_tbl[i] = '0;
            exp_q.delete();
            m_busy   = 0;
            m_age    = 0;
            zero_chk = 1;
            started  = 1;
        end else if (started) begin
            if (m_busy) begin
                if (m_age >= 2 && bus.out_ready) begin
                    m_busy = 0;
                    void'(exp_q.pop_front());
                    n_done++;
                end else begin
                    m_age++;
                end
            end else if (bus.tbl_we) begin
                if (int'(bus.tbl_addr) < N_ENTRIES) m_tbl[bus.tbl_addr] = bus.tbl_wdata;
            end else if (bus.in_valid) begin
                int seg;
                seg = int'(bus.z_in) / 16;
                exp_q.push_back({bus.z_in, 8'(seg * 16), m_tbl[seg], m_tbl[seg + 1]});
                acc_t.push_back(m_cyc);
                m_busy   = 1;
                m_age    = 0;
                zero_chk = 0;
            end
        end
        m_cyc++;
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", W'(bus.in_ready), W'(!m_busy && !bus.tbl_we));
            chk("tbl_ready", W'(bus.tbl_ready), W'(!m_busy));
            chk("out_valid", W'(bus.out_valid), W'(m_busy && m_age >= 2));
            if (m_busy && m_age >= 2 && exp_q.size() > 0)
                chk("operands", {bus.z_value, bus.integer_part, bus.base, bus.next_data}, exp_q[0]);
            else if (zero_chk)
                chk("reset_outputs", {bus.z_value, bus.integer_part, bus.base, bus.next_data}, '0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [DATA_W-1:0] d);
        bus.tbl_we    = 1'b1;
        bus.tbl_addr  = ADDR_W'(a);
        bus.tbl_wdata = d;
        tick();
        bus.tbl_we    = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bus.in_ready && n < 20) begin tick(); n++; end
        if (!bus.in_ready) chk("accept_timeout", W'(bus.in_ready), W'(1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!bus.out_valid && n < 10) begin tick(); n++; end
        if (!bus.out_valid) chk("drain_timeout", W'(bus.out_valid), W'(1));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    // Send z, check latency and literal operands, then consume. Optional
    // inject drives a table write (addr 5) during RD_BASE, which must be dropped.
    task automatic send_expect(input logic [7:0] z, input logic [7:0] e_int,
                               input logic [7:0] e_base, input logic [7:0] e_next,
                               input bit inject);
        int lat;
        bus.z_in      = z;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        #1;
        wait_ready();
        tick();                       // accept edge N
        bus.in_valid = 1'b0;
        lat = 0;
        if (inject) begin
            bus.tbl_we    = 1'b1;
            bus.tbl_addr  = 5'd5;
            bus.tbl_wdata = 8'h11;
            tick();
            bus.tbl_we    = 1'b0;
            lat = 1;
        end
        while (!bus.out_valid && lat < 10) begin tick(); lat++; end
        chk("valid_edge", W'(lat + 1), W'(3));  // valid when sampled at edge N+3
        chk("z_value", W'(bus.z_value), W'(z));
        chk("integer_part", W'(bus.integer_part), W'(e_int));
        chk("base", W'(bus.base), W'(e_base));
        chk("next_data", W'(bus.next_data), W'(e_next));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("post_out_valid", W'(bus.out_valid), W'(0));
        chk("post_in_ready", W'(bus.in_ready), W'(1));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int s0, k, d0;
        bus.in_valid = 0; bus.z_in = '0; bus.tbl_we = 0; bus.tbl_addr = '0;
        bus.tbl_wdata = '0; bus.out_ready = 0;
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk("rst_in_ready", W'(bus.in_ready), W'(1));
        chk("rst_tbl_ready", W'(bus.tbl_ready), W'(1));
        chk("rst_out_valid", W'(bus.out_valid), W'(0));
        chk("rst_state", W'(dbg_state), W'(0));
        chk("rst_outputs", {bus.z_value, bus.integer_part, bus.base, bus.next_data}, '0);

        for (int i = 0; i < 16; i++) load(i, 8'(16 * i));
        load(16, 8'd255);

        send_expect(8'h37, 8'h30, 8'd48, 8'd64, 0);
        send_expect(8'hF5, 8'hF0, 8'd240, 8'd255, 0);   // top segment reads entry 16
        send_expect(8'h00, 8'h00, 8'd0, 8'd16, 0);

        // Backpressure with a second z waiting
        bus.z_in = 8'h42; bus.in_valid = 1'b1; #1;
        wait_ready();
        tick();
        k = 0;
        while (!bus.out_valid && k < 10) begin tick(); k++; end
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", W'(bus.in_ready), W'(0));
            chk("bp_hold", {bus.z_value, bus.integer_part, bus.base, bus.next_data},
                {8'h42, 8'h40, 8'd64, 8'd80});
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("bp_release_in_ready", W'(bus.in_ready), W'(1));
        tick();                       // queued 0x42 accepted here
        bus.in_valid = 1'b0;
        drain();

        // Write collides with input in IDLE: write wins, z waits
        bus.tbl_we = 1'b1; bus.tbl_addr = 5'd3; bus.tbl_wdata = 8'hAA;
        bus.z_in = 8'h37; bus.in_valid = 1'b1; #1;
        chk("coll_in_ready", W'(bus.in_ready), W'(0));
        chk("coll_tbl_ready", W'(bus.tbl_ready), W'(1));
        tick();
        bus.tbl_we = 1'b0; bus.in_valid = 1'b0; #1;
        chk("coll_not_accepted", W'(bus.tbl_ready), W'(1));
        send_expect(8'h37, 8'h30, 8'hAA, 8'd64, 0);

        // Write during RD_BASE is dropped
        send_expect(8'h11, 8'h10, 8'd16, 8'd32, 1);
        send_expect(8'h5A, 8'h50, 8'd80, 8'd96, 0);

        // Out-of-range write is dropped (20 must not alias onto entry 4)
        load(20, 8'h99);
        send_expect(8'h40, 8'h40, 8'd64, 8'd80, 0);
        send_expect(8'hF0, 8'hF0, 8'd240, 8'd255, 0);

        // Reset in RD_NEXT aborts and clears the table
        bus.z_in = 8'h37; bus.in_valid = 1'b1; #1;
        wait_ready();
        tick();                       // RD_BASE
        bus.in_valid = 1'b0;
        tick();                       // RD_NEXT
        rst = 1'b0;
        tick();
        chk("mid_rst_out_valid", W'(bus.out_valid), W'(0));
        chk("mid_rst_in_ready", W'(bus.in_ready), W'(1));
        chk("mid_rst_outputs", {bus.z_value, bus.integer_part, bus.base, bus.next_data}, '0);
        rst = 1'b1;
        tick();
        send_expect(8'h37, 8'h30, 8'd0, 8'd0, 0);

        // Random table contents
        for (int i = 0; i < N_ENTRIES; i++) load(i, 8'($urandom_range(0, 255)));

        // Back-to-back with out_ready held high
        s0 = acc_t.size();
        d0 = n_done;
        k = 0;
        bus.out_ready = 1'b1;
        bus.z_in = 8'($urandom_range(0, 255));
        bus.in_valid = 1'b1;
        for (int c = 0; c < 60 && k < 4; c++) begin
            tick();
            if (acc_t.size() > s0 + k) begin
                k++;
                bus.z_in = 8'($urandom_range(0, 255));
            end
        end
        bus.in_valid = 1'b0;
        repeat (6) tick();
        bus.out_ready = 1'b0;
        chk("b2b_accepts", W'(acc_t.size() - s0), W'(4));
        for (int j = 1; j < 4; j++)
            if (acc_t.size() > s0 + j)
                chk("b2b_interval", W'(acc_t[s0 + j] - acc_t[s0 + j - 1]), W'(4));
        chk("b2b_done", W'(n_done - d0), W'(4));

        // Random traffic, including writes in every state and out-of-range addresses
        for (int c = 0; c < 600; c++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.z_in      = 8'($urandom_range(0, 255));
            bus.tbl_we    = ($urandom_range(0, 9) == 0);
            bus.tbl_addr  = 5'($urandom_range(0, 20));
            bus.tbl_wdata = 8'($urandom_range(0, 255));
            bus.out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        bus.in_valid = 1'b0; bus.tbl_we = 1'b0; bus.out_ready = 1'b1;
        repeat (8) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
